// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the instruction sequencer: phase codes, trap cause
// codes and the access alignment helper.
package cpu_seq_pkg;

  // Phase encoding; the numeric codes are seen by the datapath on `phase`.
  typedef enum logic [2:0] {
    ST_TRAP   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_READ   = 3'd3,
    ST_EXEC   = 3'd4,
    ST_MEM    = 3'd5,
    ST_WB     = 3'd6,
    ST_NEXT   = 3'd7
  } state_e;

  localparam logic [2:0] CAUSE_FETCH_MISALIGN = 3'd0;
  localparam logic [2:0] CAUSE_ILLEGAL        = 3'd1;
  localparam logic [2:0] CAUSE_LOAD_MISALIGN  = 3'd2;
  localparam logic [2:0] CAUSE_STORE_MISALIGN = 3'd3;
  localparam logic [2:0] CAUSE_BUS_TIMEOUT    = 3'd4;

  // Size code 0 = byte, 1 = half, 2 = word; code 3 is treated like a word.
  function automatic logic is_misaligned(input logic [1:0] low_bits,
                                         input logic [1:0] size);
    logic bad;
    bad = 1'b0;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = low_bits[0];
      default: bad = |low_bits;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/cpu_seq_bus_timer.sv
// Wait-cycle counter shared by FETCH and MEM. `expired` flags the cycle in
// which the MAX_WAIT-th cycle without ready completes; ready in that same
// cycle suppresses it. With MAX_WAIT = 0 the counter disappears entirely.
module cpu_seq_bus_timer #(
  parameter int MAX_WAIT = 0
) (
  input  logic CLK100MHZ,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  input  logic ready,
  output logic expired
);

  if (MAX_WAIT > 0) begin : g_timer
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] wait_cnt;

    // Count cycles spent waiting; cleared whenever no handshake is pending.
    always_ff @(posedge CLK100MHZ) begin
      if (!rst_n || clear) begin
        wait_cnt <= '0;
      end else if (count_en && !ready) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end

    assign expired = count_en && !ready && (wait_cnt == CW'(MAX_WAIT - 1));
  end else begin : g_no_timer
    logic unused_timer_inputs;
    assign unused_timer_inputs = ^{CLK100MHZ, rst_n, clear, count_en, ready};
    assign expired = 1'b0;
  end

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle RV32I instruction sequencer. Owns pc, ir and the phase code,
// skips phases an instruction does not need, waits on memory handshakes and
// redirects to TRAP_VEC on illegal instructions, misalignment or bus timeout.
// Handshake: a request (imem_req/dmem_req) is held from the first cycle of
// FETCH/MEM until the cycle in which the matching ready is high; it is only
// ever dropped early by a timeout trap or by reset.
module cpu_seq
  import cpu_seq_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h100),
  parameter int              CNT_W     = 32,
  parameter int              MAX_WAIT  = 0
) (
  input  logic             CLK100MHZ,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ir,
  input  logic             dec_illegal,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_rd_en,
  input  logic [1:0]       dec_mem_size,
  input  logic [XLEN-1:0]  addr,
  input  logic             taken_branch,
  output logic             dmem_req,
  input  logic             dmem_ready,
  output logic [2:0]       phase,
  output logic             rf_we,
  output logic [XLEN-1:0]  pc,
  output logic             trap,
  output logic [2:0]       trap_cause,
  output logic [XLEN-1:0]  trap_epc,
  output logic [CNT_W-1:0] instret
);

  state_e state;
  logic   bus_wait;
  logic   bus_ready;
  logic   bus_expired;

  assign bus_wait  = (state == ST_FETCH) || (state == ST_MEM);
  assign bus_ready = (state == ST_FETCH) ? imem_ready : dmem_ready;

  cpu_seq_bus_timer #(.MAX_WAIT(MAX_WAIT)) u_bus_timer (
    .CLK100MHZ (CLK100MHZ),
    .rst_n     (rst_n),
    .clear     (!bus_wait),
    .count_en  (bus_wait),
    .ready     (bus_ready),
    .expired   (bus_expired)
  );

  // Phase sequencing plus pc / ir / instret / trap bookkeeping.
  // Cause and epc are captured on entry to TRAP so they are already valid
  // while the trap pulse is visible.
  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      state      <= ST_FETCH;
      pc         <= RESET_VEC;
      ir         <= '0;
      instret    <= '0;
      trap_epc   <= '0;
      trap_cause <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ready) begin
            ir    <= imem_rdata;
            state <= ST_DECODE;
          end else if (bus_expired) begin
            state      <= ST_TRAP;
            trap_cause <= CAUSE_BUS_TIMEOUT;
            trap_epc   <= pc;
          end
        end
        ST_DECODE: begin
          if (dec_illegal) begin
            state      <= ST_TRAP;
            trap_cause <= CAUSE_ILLEGAL;
            trap_epc   <= pc;
          end else begin
            state <= ST_READ;
          end
        end
        ST_READ: state <= ST_EXEC;
        ST_EXEC: begin
          if (dec_is_load || dec_is_store) begin
            if (is_misaligned(addr[1:0], dec_mem_size)) begin
              state      <= ST_TRAP;
              trap_cause <= dec_is_load ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN;
              trap_epc   <= pc;
            end else begin
              state <= ST_MEM;
            end
          end else begin
            state <= dec_rd_en ? ST_WB : ST_NEXT;
          end
        end
        ST_MEM: begin
          if (dmem_ready) begin
            state <= dec_is_load ? ST_WB : ST_NEXT;
          end else if (bus_expired) begin
            state      <= ST_TRAP;
            trap_cause <= CAUSE_BUS_TIMEOUT;
            trap_epc   <= pc;
          end
        end
        ST_WB: state <= ST_NEXT;
        ST_NEXT: begin
          if (taken_branch && (addr[1:0] != 2'b00)) begin
            state      <= ST_TRAP;
            trap_cause <= CAUSE_FETCH_MISALIGN;
            trap_epc   <= pc;
          end else begin
            pc      <= taken_branch ? addr : pc + XLEN'(4);
            instret <= instret + CNT_W'(1);
            state   <= ST_FETCH;
          end
        end
        ST_TRAP: begin
          pc    <= TRAP_VEC;
          state <= ST_FETCH;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

  assign phase     = state;
  assign imem_req  = (state == ST_FETCH);
  assign dmem_req  = (state == ST_MEM);
  assign rf_we     = (state == ST_WB);
  assign trap      = (state == ST_TRAP);
  assign imem_addr = pc;

endmodule
